// File: rtl/cntr_seq_pkg.sv
// Shared types and constants for the counter-increment sequencer.
package cntr_seq_pkg;

    typedef enum logic [1:0] {
        DIR_PLUS,
        DIR_MINUS,
        DIR_DIM
    } dir_e;

    localparam int DEF_NSTG     = 12;
    localparam int DEF_PULSE_TP = 4;
    localparam int MAX_NSTG     = 16;

    // Stage numbers are 1-based; the result is the one-hot TP pattern for that stage.
    function automatic logic [MAX_NSTG-1:0] stage_to_tp(input int unsigned stage);
        return MAX_NSTG'(1) << (stage - 1);
    endfunction

endpackage

// File: rtl/cntr_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set request bit.
module cntr_prio_enc #(
    parameter int N  = 20,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [AW-1:0] idx,
    output logic          valid
);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        idx   = '0;
        valid = 1'b0;
        // Scanning downwards lets the lowest set bit make the final assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = AW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cntr_incr_seq.sv
// Counter-increment sequencer: request cells, time-pulse ring, cycle-stealing arbiter.
// Define CNT_DINC_EN to add diminish requests (dup) and the DINC pulse.
module cntr_incr_seq
    import cntr_seq_pkg::*;
#(
    parameter int NCHAN    = 20,
    parameter int NSTG     = DEF_NSTG,
    parameter int PULSE_TP = DEF_PULSE_TP,
    parameter int AW       = $clog2(NCHAN)
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic             STEP,
    input  logic             GOJAM,
    input  logic             INHINC,
    input  logic [NCHAN-1:0] pup,
    input  logic [NCHAN-1:0] mup,
`ifdef CNT_DINC_EN
    input  logic [NCHAN-1:0] dup,
    output logic             DINC,
`endif
    output logic [NSTG-1:0]  TP,
    output logic             INKL,
    output logic [AW-1:0]    CADR,
    output logic             PINC,
    output logic             MINC,
    output logic             LOST
);

    localparam logic [NSTG-1:0] TP_FIRST = NSTG'(stage_to_tp(1));
    localparam logic [NSTG-1:0] TP_PULSE = NSTG'(stage_to_tp(PULSE_TP));

    logic [NCHAN-1:0] plus_pend, minus_pend;
    logic [NCHAN-1:0] conflict, eligible, svc, pm_clr;
    logic [AW-1:0]    win_idx;
    logic             win_valid, wrap, grant, lost_hit, pulse_slot;
    dir_e             dir, win_dir;
`ifdef CNT_DINC_EN
    logic [NCHAN-1:0] dim_pend, dim_clr;
`endif

    cntr_prio_enc #(.N(NCHAN), .AW(AW)) u_prio (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // A channel asking for both plus and minus cancels out and is not eligible.
    always_comb begin
        wrap     = STEP & TP[NSTG-1];
        conflict = plus_pend & minus_pend;
        eligible = plus_pend ^ minus_pend;
`ifdef CNT_DINC_EN
        eligible = eligible | dim_pend;
`endif
    end

    always_comb begin
        grant    = wrap & win_valid & ~INHINC;
        svc      = grant ? (NCHAN'(1) << win_idx) : '0;
        win_dir  = plus_pend[win_idx] ? DIR_PLUS : DIR_MINUS;
        lost_hit = |((pup & plus_pend) | (mup & minus_pend));
`ifdef CNT_DINC_EN
        dim_clr  = svc & dim_pend;
        pm_clr   = (wrap ? conflict : '0) | (svc & ~dim_pend);
        if (dim_pend[win_idx]) win_dir = DIR_DIM;
        lost_hit = lost_hit | (|(dup & dim_pend));
`else
        pm_clr   = (wrap ? conflict : '0) | svc;
`endif
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst)        TP <= TP_FIRST;
        else if (GOJAM) TP <= TP_FIRST;
        else if (STEP)  TP <= {TP[NSTG-2:0], TP[NSTG-1]};
    end

    // New requests are OR-ed in after clearing, so a set beats a clear on the same edge.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            plus_pend  <= '0;
            minus_pend <= '0;
        end else if (GOJAM) begin
            plus_pend  <= '0;
            minus_pend <= '0;
        end else begin
            plus_pend  <= (plus_pend & ~pm_clr) | pup;
            minus_pend <= (minus_pend & ~pm_clr) | mup;
        end
    end

`ifdef CNT_DINC_EN
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst)        dim_pend <= '0;
        else if (GOJAM) dim_pend <= '0;
        else            dim_pend <= (dim_pend & ~dim_clr) | dup;
    end
`endif

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst)                      LOST <= 1'b0;
        else if (!GOJAM && lost_hit)  LOST <= 1'b1;
    end

    // INKL, CADR and the direction only change on a wrap edge or GOJAM.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            INKL <= 1'b0;
            CADR <= '0;
            dir  <= DIR_PLUS;
        end else if (GOJAM) begin
            INKL <= 1'b0;
            CADR <= '0;
        end else if (wrap) begin
            INKL <= grant;
            if (grant) begin
                CADR <= win_idx;
                dir  <= win_dir;
            end
        end
    end

    assign pulse_slot = |(TP & TP_PULSE);
    assign PINC = INKL & (dir == DIR_PLUS)  & pulse_slot;
    assign MINC = INKL & (dir == DIR_MINUS) & pulse_slot;
`ifdef CNT_DINC_EN
    assign DINC = INKL & (dir == DIR_DIM)   & pulse_slot;
`endif

endmodule

// File: tb/tb_cntr_incr_seq.sv
// Self-checking bench for cntr_incr_seq: reference model feeds a scoreboard, monitor compares.
module tb_cntr_incr_seq;

    localparam int NCHAN    = 20;
    localparam int NSTG     = 12;
    localparam int PULSE_TP = 4;
    localparam int AW       = $clog2(NCHAN);

    logic             CLOCK = 1'b0;
    logic             rst   = 1'b0;
    logic             STEP  = 1'b0;
    logic             GOJAM = 1'b0;
    logic             INHINC = 1'b0;
    logic [NCHAN-1:0] pup = '0;
    logic [NCHAN-1:0] mup = '0;
    logic [NSTG-1:0]  TP;
    logic             INKL, PINC, MINC, LOST;
    logic [AW-1:0]    CADR;

    cntr_incr_seq #(.NCHAN(NCHAN), .NSTG(NSTG), .PULSE_TP(PULSE_TP), .AW(AW)) dut (
        .CLOCK (CLOCK), .rst (rst), .STEP (STEP), .GOJAM (GOJAM), .INHINC (INHINC),
        .pup (pup), .mup (mup), .TP (TP), .INKL (INKL), .CADR (CADR),
        .PINC (PINC), .MINC (MINC), .LOST (LOST)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [NSTG-1:0] tp;
        logic            inkl;
        logic [AW-1:0]   cadr;
        logic            pinc;
        logic            minc;
        logic            lost;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW:0]   svc_q[$];   // {channel, plus} for each predicted pulse
    logic [AW:0]   obs_q[$];   // {channel, plus} for each observed pulse
    int            n_checks = 0;
    int            n_errors = 0;
    int            pinc_cycles = 0;
    int            minc_cycles = 0;

    // Reference model: stage number, pending request sets, current counter cycle.
    int               stage_m;
    bit [NCHAN-1:0]   plus_m, minus_m;
    bit               inkl_m, dplus_m, lost_m, pulse_prev_m;
    int               cadr_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        stage_m = 1; plus_m = '0; minus_m = '0;
        inkl_m = 1'b0; cadr_m = 0; dplus_m = 1'b1; lost_m = 1'b0; pulse_prev_m = 1'b0;
    endtask

    task automatic model_step(input logic [NCHAN-1:0] p, input logic [NCHAN-1:0] m,
                              input logic st, input logic gj, input logic ih);
        bit [NCHAN-1:0] np, nm;
        int win;
        if (gj) begin
            stage_m = 1; plus_m = '0; minus_m = '0; inkl_m = 1'b0; cadr_m = 0;
            return;
        end
        for (int i = 0; i < NCHAN; i++)
            if ((p[i] && plus_m[i]) || (m[i] && minus_m[i])) lost_m = 1'b1;
        np = plus_m;
        nm = minus_m;
        if (st && stage_m == NSTG) begin
            win = -1;
            for (int i = 0; i < NCHAN; i++) begin
                if (plus_m[i] && minus_m[i]) begin
                    np[i] = 1'b0; nm[i] = 1'b0;
                end else if (win < 0 && (plus_m[i] || minus_m[i])) begin
                    win = i;
                end
            end
            if (win >= 0 && !ih) begin
                inkl_m = 1'b1; cadr_m = win; dplus_m = plus_m[win];
                np[win] = 1'b0; nm[win] = 1'b0;
            end else begin
                inkl_m = 1'b0;
            end
        end
        plus_m  = np | p;
        minus_m = nm | m;
        if (st) stage_m = (stage_m == NSTG) ? 1 : stage_m + 1;
    endtask

    // Drive one clock edge's worth of inputs, advance the model, push expectations.
    task automatic tick(input logic [NCHAN-1:0] p, input logic [NCHAN-1:0] m,
                        input logic st, input logic gj, input logic ih);
        exp_t e;
        bit   pulse;
        pup = p; mup = m; STEP = st; GOJAM = gj; INHINC = ih;
        @(posedge CLOCK);
        model_step(p, m, st, gj, ih);
        pulse  = inkl_m && (stage_m == PULSE_TP);
        e      = '0;
        e.tp[stage_m-1] = 1'b1;
        e.inkl = inkl_m;
        e.cadr = AW'(cadr_m);
        e.pinc = pulse && dplus_m;
        e.minc = pulse && !dplus_m;
        e.lost = lost_m;
        exp_q.push_back(e);
        if (pulse && !pulse_prev_m) svc_q.push_back({AW'(cadr_m), dplus_m});
        pulse_prev_m = pulse;
        #1;
        pup = '0; mup = '0; GOJAM = 1'b0;
    endtask

    task automatic idle(input int n, input logic ih);
        repeat (n) tick('0, '0, 1'b1, 1'b0, ih);
    endtask

    function automatic logic [NCHAN-1:0] rnd_req();
        logic [31:0] r;
        r = $urandom & $urandom & $urandom & $urandom;
        return ($urandom_range(0, 2) == 0) ? NCHAN'(r) : '0;
    endfunction

    // Monitor: per-cycle state against the queue, pulse events against the scoreboard.
    initial begin : monitor
        exp_t        e;
        logic [AW:0] s;
        logic        pulse_prev = 1'b0;
        logic        rise;
        forever begin
            @(negedge CLOCK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state{tp,inkl,pinc,minc,lost}", 64'({TP, INKL, PINC, MINC, LOST}),
                      64'({e.tp, e.inkl, e.pinc, e.minc, e.lost}));
                if (e.inkl) check("cadr", 64'(CADR), 64'(e.cadr));
            end
            rise = (PINC | MINC) && !pulse_prev;
            pulse_prev = PINC | MINC;
            if (PINC) pinc_cycles++;
            if (MINC) minc_cycles++;
            if (rise) begin
                obs_q.push_back({CADR, PINC});
                if (svc_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL pulse_event: unexpected pulse CADR=%0d PINC=%0b at %0t", CADR, PINC, $time);
                end else begin
                    s = svc_q.pop_front();
                    check("pulse_event{cadr,plus}", 64'({CADR, PINC}), 64'(s));
                end
            end else if (svc_q.size() > 0) begin
                s = svc_q.pop_front();
                n_checks++; n_errors++;
                $display("FAIL pulse_event: no pulse, expected {cadr,plus}=0x%0h at %0t", s, $time);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int p0;
        int m0;
        bit found;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_tp",   64'(TP),   64'(1));
        check("rst_flags", 64'({INKL, PINC, MINC, LOST}), 64'(0));
        check("rst_cadr", 64'(CADR), 64'(0));
        @(negedge CLOCK); #1 rst = 1'b0;
        tick('0, '0, 1'b1, 1'b0, 1'b0);
        check("tp_after_rst", 64'(TP), 64'(2));

        // Single plus request on channel 3.
        obs_q.delete(); p0 = pinc_cycles; m0 = minc_cycles;
        tick(NCHAN'(1) << 3, '0, 1'b1, 1'b0, 1'b0);
        idle(3 * NSTG, 1'b0);
        check("pup3_pinc_cycles", 64'(pinc_cycles - p0), 64'(1));
        check("pup3_minc_cycles", 64'(minc_cycles - m0), 64'(0));
        check("pup3_pulses", 64'(obs_q.size()), 64'(1));
        if (obs_q.size() >= 1) check("pup3_event", 64'(obs_q[0]), 64'({AW'(3), 1'b1}));

        // Plus on 7 and minus on 2 together: ascending order, back to back.
        obs_q.delete();
        tick(NCHAN'(1) << 7, NCHAN'(1) << 2, 1'b1, 1'b0, 1'b0);
        idle(4 * NSTG, 1'b0);
        check("two_req_pulses", 64'(obs_q.size()), 64'(2));
        if (obs_q.size() >= 2) begin
            check("two_req_first",  64'(obs_q[0]), 64'({AW'(2), 1'b0}));
            check("two_req_second", 64'(obs_q[1]), 64'({AW'(7), 1'b1}));
        end

        // Plus and minus on the same channel cancel.
        obs_q.delete();
        tick(NCHAN'(1) << 5, NCHAN'(1) << 5, 1'b1, 1'b0, 1'b0);
        idle(4 * NSTG, 1'b0);
        check("cancel_pulses", 64'(obs_q.size()), 64'(0));

        // INHINC across two wraps, then a duplicate request, then release.
        obs_q.delete();
        tick(NCHAN'(1), '0, 1'b1, 1'b0, 1'b1);
        idle(2 * NSTG + 2, 1'b1);
        check("inhinc_pulses", 64'(obs_q.size()), 64'(0));
        check("lost_before_dup", 64'(LOST), 64'(0));
        tick(NCHAN'(1), '0, 1'b1, 1'b0, 1'b1);
        check("lost_after_dup", 64'(LOST), 64'(1));
        idle(3 * NSTG, 1'b0);
        check("inhinc_release_pulses", 64'(obs_q.size()), 64'(1));
        if (obs_q.size() >= 1) check("inhinc_release_event", 64'(obs_q[0]), 64'({AW'(0), 1'b1}));

        // GOJAM at stage 3 of a counter cycle kills the pulse and the request.
        obs_q.delete();
        tick(NCHAN'(1) << 1, '0, 1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 4 * NSTG && !found; k++) begin
            if (inkl_m && stage_m == 3) found = 1'b1;
            else tick('0, '0, 1'b1, 1'b0, 1'b0);
        end
        check("gojam_reached_stage3", 64'(found), 64'(1));
        check("gojam_inkl_before", 64'(INKL), 64'(1));
        tick('0, '0, 1'b0, 1'b1, 1'b0);
        check("gojam_tp", 64'(TP), 64'(1));
        check("gojam_inkl", 64'(INKL), 64'(0));
        check("gojam_lost_kept", 64'(LOST), 64'(1));
        idle(3 * NSTG, 1'b0);
        check("gojam_pulses", 64'(obs_q.size()), 64'(0));

        // Randomised traffic against the model.
        for (int k = 0; k < 1500; k++)
            tick(rnd_req(), rnd_req(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0));
        idle(3 * NSTG, 1'b0);

        // Asynchronous reset mid-run.
        @(negedge CLOCK); #1 rst = 1'b1;
        #1;
        check("midrst_tp", 64'(TP), 64'(1));
        check("midrst_flags", 64'({INKL, PINC, MINC, LOST}), 64'(0));
        check("midrst_cadr", 64'(CADR), 64'(0));
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK); #1 rst = 1'b0;
        model_reset();
        tick('0, '0, 1'b1, 1'b0, 1'b0);
        check("midrst_tp_step", 64'(TP), 64'(2));
        idle(NSTG, 1'b0);

        @(negedge CLOCK); #1;
        check("scoreboard_drained", 64'(exp_q.size() + svc_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
